reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Round-robin arbiter that shares one N-bit holding register among M requesters. Each requester presents a write request with its data. The block grants one requester at a time, loads that requester's data into the shared register, and reports which requester wrote last. It sits between several producer blocks and a single shared register or configuration word, and it sequences the register's enable and data.

## Interface
Parameters:
- `N`, 8, data width of the shared register.
- `M`, 4, number of requesters (M >= 2).
- `S`, derived as $clog2(M), width of the source index.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (rst = 0 resets; release is synchronous to clk).
- `req`  in  M  request per requester; bit i held high while requester i wants to write.
- `din`  in  M*N  flattened data; slice [i*N +: N] belongs to requester i.
- `clr`  in  1  synchronous clear of the shared register.
- `gnt`  out  M  registered one-hot grant; high for exactly one cycle per transaction.
- `q`  out  N  shared register contents.
- `q_src`  out  S  index of the requester that last wrote q.
- `q_valid`  out  1  high once q holds requester data since reset or the last clr.
- `busy`  out  1  high while a grant cycle is in progress (state GRANT).

## Operation
- FSM has two states, IDLE and GRANT. Reset state is IDLE.
- Internal state:
  - `ptr` (S bits): the round-robin start point.
  - `widx` (S bits): the registered winner.
- IDLE:
  - If `req` != 0, the winner is the first set bit scanning ptr, ptr+1, ..., M-1, 0, ..., ptr-1.
  - At the clock edge: widx <= winner, gnt <= onehot(winner), state <= GRANT.
  - If `req` == 0, the block stays in IDLE and gnt = 0.
- GRANT:
  - At the clock edge: q <= din[widx*N +: N], q_src <= widx, q_valid <= 1.
  - Also at that edge: ptr <= (widx+1) mod M (wraps M-1 -> 0), gnt <= 0, state <= IDLE.
- Handshake:
  - The requester holds req and din stable until it sees its gnt bit high.
  - Its data is captured at the rising edge that ends the gnt cycle.
  - The requester may drop req in the cycle after gnt.
  - A req still high after that is a new request.
- Data is taken from `din` during the GRANT cycle, not from the IDLE cycle.
- Dropping req during GRANT does not cancel the write; the transaction completes.
- `req` is ignored while in GRANT; pending requests are arbitrated in the following IDLE cycle.
- `clr`:
  - When high at an edge: q <= 0, q_src <= 0, q_valid <= 0.
  - `clr` has priority over a GRANT write in the same cycle. That write is discarded, but gnt still pulses and ptr still advances, so the transaction counts as consumed.
  - `clr` does not affect the FSM, ptr or gnt.
- Reset (rst = 0, at any time including mid-GRANT):
  - state = IDLE, ptr = 0, widx = 0, gnt = 0, q = 0, q_src = 0, q_valid = 0, busy = 0.
  - A GRANT cut by reset performs no write.

## Timing
- Request to gnt: a req sampled in IDLE at edge k gives gnt high in cycle k+1.
- Gnt to write: q updates at edge k+2, visible in cycle k+2.
- Throughput: at most one write every 2 cycles (GRANT is always followed by at least one IDLE cycle).
- Fairness: under continuous requests from all M requesters, each is granted exactly once every 2*M cycles.
- Outputs `gnt`, `q`, `q_src`, `q_valid` and `busy` are registered, with no combinational paths from inputs.

## Test plan
- Reset and single request:
  - Reset, then hold req = 0001 with din[0] = 8'hA5.
  - Expected: gnt = 0001 for one cycle, then q = A5, q_src = 0, q_valid = 1.
  - All outputs read 0 while rst = 0.
- Round-robin rotation (M = 4):
  - Hold req = 1111 continuously with din[i] = 8'h10+i.
  - Expected grant order 0, 1, 2, 3, 0, each gnt separated by one idle cycle.
  - Expected q sequence 10, 11, 12, 13, 10.
- Pointer wrap and skip:
  - Grant requester 3 alone, then assert req = 0101.
  - Expected: requester 0 is granted first (ptr wrapped to 0), then requester 2.
- clr collision:
  - Assert clr in the same cycle gnt = 0010 is high, with din[1] = 8'h3C.
  - Expected: q = 0, q_valid = 0, and the next grant goes to requester 2 (ptr advanced).
- Reset mid-operation:
  - Drop rst during a GRANT cycle that would load 8'hFF.
  - Expected: q stays 0, gnt clears immediately, and after release the first grant starts from requester 0.
- Request drop during GRANT:
  - Requester 2 drops req in its gnt cycle.
  - Expected: the write still occurs, q = din[2], q_src = 2.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one N-bit holding register among M requesters.
// Every transaction is one IDLE arbitration edge, then one GRANT cycle whose closing edge writes q.
module reg_write_arbiter #(
  parameter  int unsigned N = 8,
  parameter  int unsigned M = 4,
  localparam int unsigned S = $clog2(M)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M-1:0]   req,
  input  logic [M*N-1:0] din,
  input  logic           clr,
  output logic [M-1:0]   gnt,
  output logic [N-1:0]   q,
  output logic [S-1:0]   q_src,
  output logic           q_valid,
  output logic           busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [S-1:0] r_ptr;
  logic [S-1:0] w_ptr_nxt;
  logic [S-1:0] r_widx;
  logic [S-1:0] w_widx_nxt;
  logic [S-1:0] w_win;
  logic [S-1:0] w_cand;
  logic         w_found;
  logic [N-1:0] w_din_sel;
  logic [M-1:0] r_gnt;
  logic [M-1:0] w_gnt_nxt;
  logic [N-1:0] r_q;
  logic [N-1:0] w_q_nxt;
  logic [S-1:0] r_q_src;
  logic [S-1:0] w_q_src_nxt;
  logic         r_q_valid;
  logic         w_q_valid_nxt;
  logic         r_busy;
  logic         w_busy_nxt;

  // First requester at or after r_ptr, wrapping modulo M.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < M; k++) begin
      w_cand = S'((32'(r_ptr) + k) % M);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // Winner's data slice, sampled during the GRANT cycle.
  always_comb begin
    w_din_sel = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (r_widx == S'(i)) begin
        w_din_sel = din[i*N +: N];
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_widx_nxt    = r_widx;
    w_gnt_nxt     = '0;
    w_busy_nxt    = 1'b0;
    w_q_nxt       = r_q;
    w_q_src_nxt   = r_q_src;
    w_q_valid_nxt = r_q_valid;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_widx_nxt  = w_win;
          w_gnt_nxt   = M'(1) << w_win;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        w_q_nxt       = w_din_sel;
        w_q_src_nxt   = r_widx;
        w_q_valid_nxt = 1'b1;
        w_ptr_nxt     = (r_widx == S'(M - 1)) ? '0 : r_widx + S'(1);
        w_state_nxt   = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A clear wins over a same-edge write; the grant itself still counts as consumed.
    if (clr) begin
      w_q_nxt       = '0;
      w_q_src_nxt   = '0;
      w_q_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr     <= '0;
      r_widx    <= '0;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_q       <= '0;
      r_q_src   <= '0;
      r_q_valid <= 1'b0;
    end else begin
      r_ptr     <= w_ptr_nxt;
      r_widx    <= w_widx_nxt;
      r_gnt     <= w_gnt_nxt;
      r_busy    <= w_busy_nxt;
      r_q       <= w_q_nxt;
      r_q_src   <= w_q_src_nxt;
      r_q_valid <= w_q_valid_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign busy    = r_busy;
  assign q       = r_q;
  assign q_src   = r_q_src;
  assign q_valid = r_q_valid;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus random transactions,
// checked against a transaction-level round-robin model.
module tb_reg_write_arbiter;

  localparam int unsigned N = 8;
  localparam int unsigned M = 4;
  localparam int unsigned S = $clog2(M);

  logic           clk = 1'b0;
  logic           rst;
  logic [M-1:0]   req;
  logic [M*N-1:0] din;
  logic           clr;
  logic [M-1:0]   gnt;
  logic [N-1:0]   q;
  logic [S-1:0]   q_src;
  logic           q_valid;
  logic           busy;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: round-robin start point and the shared register image.
  int         m_ptr;
  logic [7:0] m_q;
  int         m_src;
  bit         m_valid;

  reg_write_arbiter #(.N(N), .M(M)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .din     (din),
    .clr     (clr),
    .gnt     (gnt),
    .q       (q),
    .q_src   (q_src),
    .q_valid (q_valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int pick(input int p, input logic [M-1:0] r);
    int idx;
    for (int k = 0; k < M; k++) begin
      idx = (p + k) % M;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_q = '0; m_src = 0; m_valid = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    check_eq({tag, "_q"}, q, m_q);
    check_eq({tag, "_src"}, q_src, m_src);
    check_eq({tag, "_valid"}, q_valid, m_valid);
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '1; clr = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq("rst_gnt", gnt, 0);
      check_eq("rst_q", q, 0);
      check_eq("rst_src", q_src, 0);
      check_eq("rst_valid", q_valid, 0);
      check_eq("rst_busy", busy, 0);
    end
    @(posedge clk); #1;
    rst = 1'b1; req = '0;
    m_ptr = 0;
    model_clear();
  endtask

  // One request/grant/write transaction; exp_w >= 0 additionally pins the winner.
  task automatic do_txn(input logic [M-1:0] r, input bit use_clr, input bit drop, input int exp_w);
    int w;
    bit seen;
    logic [N-1:0] exp_d;
    @(posedge clk); #1;
    req = r;
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(negedge clk);
      if (gnt != '0) seen = 1'b1;
    end
    w = pick(m_ptr, r);
    if (!seen) begin
      check_eq("gnt_timeout", 0, 1);
      req = '0;
      return;
    end
    check_eq("gnt", gnt, 32'(1) << w);
    if (exp_w >= 0) check_eq("gnt_plan", gnt, 32'(1) << exp_w);
    check_eq("busy_grant", busy, 1);
    exp_d = din[w*N +: N];
    // Scramble the losers' data so only the winner's slice can land in q.
    for (int i = 0; i < M; i++) begin
      if (i != w) din[i*N +: N] = N'($urandom);
    end
    if (drop) req = '0;
    clr = use_clr;
    @(posedge clk); #1;
    req = '0;
    clr = 1'b0;
    m_ptr = (w + 1) % M;
    if (use_clr) begin
      model_clear();
    end else begin
      m_q = exp_d; m_src = w; m_valid = 1'b1;
    end
    @(negedge clk);
    check_regs("write");
    check_eq("gnt_after", gnt, 0);
    check_eq("busy_after", busy, 0);
  endtask

  // Continuous all-request load: grants every other cycle in rotation.
  task automatic rotation();
    int lw;
    do_reset();
    for (int i = 0; i < M; i++) din[i*N +: N] = N'(8'h10 + i);
    @(negedge clk);
    req = '1;
    lw = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (cyc % 2 == 0) begin
        lw = pick(m_ptr, '1);
        check_eq("rot_gnt", gnt, 32'(1) << lw);
        check_eq("rot_plan", gnt, 32'(1) << ((cyc / 2) % M));
      end else begin
        m_ptr = (lw + 1) % M;
        m_q = N'(8'h10 + lw); m_src = lw; m_valid = 1'b1;
        check_eq("rot_idle_gnt", gnt, 0);
        check_regs("rot");
      end
    end
    req = '0;
  endtask

  task automatic reset_mid_grant();
    bit seen;
    @(posedge clk); #1;
    din[0 +: N] = 8'hFF;
    req = 4'b0001;
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(negedge clk);
      if (gnt != '0) seen = 1'b1;
    end
    if (!seen) check_eq("rmg_timeout", 0, 1);
    rst = 1'b0;
    req = '0;
    #1;
    check_eq("rmg_gnt", gnt, 0);
    check_eq("rmg_busy", busy, 0);
    check_eq("rmg_q", q, 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("rmg_q_hold", q, 0);
    check_eq("rmg_valid", q_valid, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    m_ptr = 0;
    model_clear();
    din = {M*N{1'b1}};
    do_txn(4'b1111, 1'b0, 1'b0, 0);
  endtask

  initial begin
    din = '0;
    do_reset();

    // Single request.
    din[0 +: N] = 8'hA5;
    do_txn(4'b0001, 1'b0, 1'b0, 0);
    check_eq("single_q", q, 8'hA5);

    rotation();

    // Pointer wrap and skip.
    do_txn(4'b1000, 1'b0, 1'b0, 3);
    do_txn(4'b0101, 1'b0, 1'b0, 0);
    do_txn(4'b0101, 1'b0, 1'b0, 2);

    // clr colliding with a write; the pointer must still advance.
    din[1*N +: N] = 8'h3C;
    do_txn(4'b0010, 1'b1, 1'b0, 1);
    check_eq("clr_q", q, 0);
    check_eq("clr_valid", q_valid, 0);
    do_txn(4'b0110, 1'b0, 1'b0, 2);

    // Requester drops req in its grant cycle.
    din[2*N +: N] = 8'h5A;
    do_txn(4'b0100, 1'b0, 1'b1, 2);
    check_eq("drop_q", q, 8'h5A);
    check_eq("drop_src", q_src, 2);

    reset_mid_grant();

    // Random traffic.
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < M; i++) din[i*N +: N] = N'($urandom);
      do_txn(M'($urandom_range(1, (1 << M) - 1)), ($urandom_range(0, 4) == 0),
             1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        model_clear();
        @(negedge clk);
        check_regs("idle_clr");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
